// File: rtl/qr_pkg.sv
// Shared types and default dimensions for the QR accelerator.
// Imported by the input sequencer, buffer and core wrappers.
package qr_pkg;

  localparam int N_ROWS = 3;
  localparam int N_COLS = 3;
  localparam int COL_W  = $clog2(N_COLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOADED,
    S_READ_COL,
    S_GAP,
    S_DONE,
    S_ERROR
  } qr_state_e;

endpackage

// File: rtl/qr_watchdog.sv
// Loadable down-counter: clear reloads TIMEOUT, expire when it
// reaches zero while enabled.
module qr_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= W'(TIMEOUT);
    end else if (en && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire = en && (count == '0);

endmodule

// File: rtl/qr_input_sequencer.sv
// Input-side sequencer: load the matrix buffer, then serve one
// column burst per core request with a re-arm gap between bursts.
module qr_input_sequencer
  import qr_pkg::*;
#(
  parameter int N_ROWS  = qr_pkg::N_ROWS,
  parameter int N_COLS  = qr_pkg::N_COLS,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       host_start,
  input  logic                       host_abort,
  output logic                       host_busy,
  output logic                       host_done,
  output logic                       host_err,
  output logic                       buf_start_write,
  output logic                       buf_start_read,
  input  logic                       buf_done_load,
  input  logic                       buf_done_read_vector,
  input  logic                       core_col_req,
  output logic                       core_col_valid,
  output logic [$clog2(N_COLS)-1:0]  core_col_idx
);

  localparam int CW = $clog2(N_COLS);

  if (TIMEOUT <= N_ROWS) begin : g_bad_cfg
    $error("TIMEOUT must exceed the burst length N_ROWS");
  end

  qr_state_e     state;
  qr_state_e     nxt;
  logic [CW-1:0] col;
  logic          wd_expire;
  logic          wd_en;
  logic          wd_clear;
  logic          last_col;

  assign wd_en    = (state == S_LOAD) || (state == S_READ_COL);
  assign wd_clear = (nxt != state);
  assign last_col = (col == CW'(N_COLS - 1));

  qr_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .en     (wd_en),
    .expire (wd_expire)
  );

  // Abort beats timeout beats normal flow; done flags are then ignored.
  always_comb begin
    nxt = state;
    if (host_abort) begin
      nxt = S_IDLE;
    end else if (wd_expire) begin
      nxt = S_ERROR;
    end else begin
      unique case (state)
        S_IDLE,
        S_ERROR:    if (host_start) nxt = S_LOAD;
        S_LOAD:     if (buf_done_load) nxt = S_LOADED;
        S_LOADED:   if (core_col_req) nxt = S_READ_COL;
        S_READ_COL: if (buf_done_read_vector) nxt = S_GAP;
        S_GAP:      nxt = last_col ? S_DONE : S_LOADED;
        S_DONE:     nxt = S_IDLE;
        default:    nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      col             <= '0;
      host_busy       <= 1'b0;
      host_done       <= 1'b0;
      host_err        <= 1'b0;
      buf_start_write <= 1'b0;
      buf_start_read  <= 1'b0;
      core_col_valid  <= 1'b0;
    end else begin
      state           <= nxt;
      host_busy       <= (nxt != S_IDLE) && (nxt != S_ERROR);
      host_err        <= (nxt == S_ERROR);
      buf_start_write <= (nxt == S_LOAD);
      buf_start_read  <= (nxt == S_READ_COL);
      core_col_valid  <= (state == S_READ_COL) && (nxt == S_GAP);
      host_done       <= (state == S_DONE) && !host_abort;
      if (nxt == S_IDLE || nxt == S_ERROR || nxt == S_LOAD) begin
        col <= '0;
      end else if (state == S_GAP && nxt == S_LOADED) begin
        col <= col + CW'(1);
      end
    end
  end

  assign core_col_idx = col;

endmodule

// File: tb/tb_qr_input_sequencer.sv
// Directed bench: cycle vector table plus multi-cycle sequences
// for stall, timeout and ignored restart.
module tb_qr_input_sequencer;

  localparam int N_ROWS  = 3;
  localparam int N_COLS  = 3;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       host_start;
  logic       host_abort;
  logic       host_busy;
  logic       host_done;
  logic       host_err;
  logic       buf_start_write;
  logic       buf_start_read;
  logic       buf_done_load;
  logic       buf_done_read_vector;
  logic       core_col_req;
  logic       core_col_valid;
  logic [1:0] core_col_idx;

  int n_checks = 0;
  int n_pass   = 0;

  qr_input_sequencer #(
    .N_ROWS  (N_ROWS),
    .N_COLS  (N_COLS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .host_start           (host_start),
    .host_abort           (host_abort),
    .host_busy            (host_busy),
    .host_done            (host_done),
    .host_err             (host_err),
    .buf_start_write      (buf_start_write),
    .buf_start_read       (buf_start_read),
    .buf_done_load        (buf_done_load),
    .buf_done_read_vector (buf_done_read_vector),
    .core_col_req         (core_col_req),
    .core_col_valid       (core_col_valid),
    .core_col_idx         (core_col_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (reset === 1'b0)
      chk("excl_starts", int'(buf_start_write & buf_start_read), 0);

  // in  = {reset, start, abort, done_load, done_rv, col_req}
  // exp = {busy, done, err, sw, sr, valid, idx[1:0]}
  typedef struct {
    logic [5:0] in;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[28];

  function automatic logic [7:0] outs();
    return {host_busy, host_done, host_err, buf_start_write,
            buf_start_read, core_col_valid, core_col_idx};
  endfunction

  task automatic run_matrix(input int stall, input bit poke);
    int vcnt = 0;
    int dcnt = 0;
    int rcnt = 0;
    int hold = 0;
    int post = 0;
    int last_v = -100;
    bit poked = 0;
    bit stall_ok = 1;
    host_start = 1; tick(); host_start = 0;
    chk("load_sw", int'(buf_start_write), 1);
    repeat (10) tick();
    chk("load_hold", int'(buf_start_write), 1);
    buf_done_load = 1; tick(); buf_done_load = 0;
    chk("loaded_sw", int'(buf_start_write), 0);
    core_col_req = 1;
    for (int cyc = 0; cyc < 300 && post < 4; cyc++) begin
      tick();
      host_start = 0;
      if (hold > 0) begin
        if (buf_start_read || !host_busy) stall_ok = 0;
        hold--;
        if (hold == 0) core_col_req = 1;
      end
      if (core_col_valid) begin
        chk("col_idx", int'(core_col_idx), vcnt);
        vcnt++;
        last_v = cyc;
        if (vcnt == 1 && stall > 0) begin
          core_col_req = 0;
          hold = stall;
        end
      end
      if (buf_start_read) begin
        rcnt++;
        buf_done_read_vector = (rcnt >= N_ROWS);
      end else begin
        rcnt = 0;
        buf_done_read_vector = 0;
      end
      if (poke && !poked && vcnt == 1 && buf_start_read) begin
        host_start = 1;
        poked = 1;
      end
      if (host_done) begin
        dcnt++;
        chk("done_latency", cyc - last_v, 2);
      end
      if (dcnt > 0) post++;
    end
    core_col_req = 0;
    buf_done_read_vector = 0;
    host_start = 0;
    chk("n_valid", vcnt, N_COLS);
    chk("n_done", dcnt, 1);
    chk("end_busy", int'(host_busy), 0);
    chk("end_err", int'(host_err), 0);
    if (stall > 0) chk("stall_hold", int'(stall_ok), 1);
    if (poke) chk("poked", int'(poked), 1);
  endtask

  initial begin
    int n;
    tbl[0]  = '{6'b100000, 8'b000000_00};
    tbl[1]  = '{6'b010000, 8'b100100_00};
    tbl[2]  = '{6'b000000, 8'b100100_00};
    tbl[3]  = '{6'b000100, 8'b100000_00};
    tbl[4]  = '{6'b000001, 8'b100010_00};
    tbl[5]  = '{6'b000001, 8'b100010_00};
    tbl[6]  = '{6'b000011, 8'b100001_00};
    tbl[7]  = '{6'b000001, 8'b100000_01};
    tbl[8]  = '{6'b000001, 8'b100010_01};
    tbl[9]  = '{6'b000011, 8'b100001_01};
    tbl[10] = '{6'b000001, 8'b100000_10};
    tbl[11] = '{6'b000001, 8'b100010_10};
    tbl[12] = '{6'b000011, 8'b100001_10};
    tbl[13] = '{6'b000001, 8'b100000_10};
    tbl[14] = '{6'b000001, 8'b010000_00};
    tbl[15] = '{6'b000000, 8'b000000_00};
    tbl[16] = '{6'b010000, 8'b100100_00};
    tbl[17] = '{6'b100000, 8'b000000_00};
    tbl[18] = '{6'b010000, 8'b100100_00};
    tbl[19] = '{6'b000100, 8'b100000_00};
    tbl[20] = '{6'b000001, 8'b100010_00};
    tbl[21] = '{6'b010001, 8'b100010_00};
    tbl[22] = '{6'b000011, 8'b100001_00};
    tbl[23] = '{6'b000001, 8'b100000_01};
    tbl[24] = '{6'b000001, 8'b100010_01};
    tbl[25] = '{6'b001011, 8'b000000_00};
    tbl[26] = '{6'b000000, 8'b000000_00};
    tbl[27] = '{6'b011000, 8'b000000_00};

    {reset, host_start, host_abort, buf_done_load,
     buf_done_read_vector, core_col_req} = 6'b100000;
    for (int i = 0; i < 28; i++) begin
      {reset, host_start, host_abort, buf_done_load,
       buf_done_read_vector, core_col_req} = tbl[i].in;
      tick();
      chk($sformatf("vec%0d", i), int'(outs()), int'(tbl[i].exp));
    end
    {reset, host_start, host_abort, buf_done_load,
     buf_done_read_vector, core_col_req} = 6'b000000;
    tick();

    run_matrix(0, 1);
    run_matrix(20, 0);

    host_start = 1; tick(); host_start = 0;
    n = 0;
    while (!host_err && n < 200) begin
      tick();
      n++;
    end
    chk("timeout_cycle", n, TIMEOUT + 1);
    chk("timeout_err", int'(host_err), 1);
    chk("timeout_sw", int'(buf_start_write), 0);
    chk("timeout_busy", int'(host_busy), 0);
    repeat (3) tick();
    chk("err_sticky", int'(host_err), 1);
    host_start = 1; tick(); host_start = 0;
    chk("restart_err", int'(host_err), 0);
    chk("restart_sw", int'(buf_start_write), 1);
    host_abort = 1; tick(); host_abort = 0;
    chk("abort_idle", int'(outs()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
